// File: rtl/ifetch_if.sv
// Instruction fetch bus: memory request/response, buffered instruction output
// and redirect control, bundled for the fetch unit and its environment.
interface ifetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output mem_req, mem_addr, out_valid, out_ins, out_pc, fetch_fault,
    input  mem_ack, mem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_ins, out_pc, fetch_fault,
    output mem_ack, mem_rdata, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small
// instruction FIFO, with redirect handling and sticky address-fault detection.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_3400,
  parameter int          DEPTH    = 4
) (
  input logic     clk,
  input logic     rst,
  ifetch_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {FETCH, DISCARD, FAULT} state_t;

  state_t            state, state_mid, state_next;
  logic [31:0]       fetch_pc, fetch_pc_next;
  logic [CNT_W-1:0]  count, count_next;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              mem_req, mem_req_next;
  logic [31:0]       mem_addr, mem_addr_next;
  logic              fault;
  logic              ack, hold, push, pop;
  logic [31:0]       buf_ins [DEPTH];
  logic [31:0]       buf_pc  [DEPTH];

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IMEM_LO) || (a > IMEM_HI);
  endfunction

  always_comb begin
    ack  = mem_req && bus.mem_ack;
    hold = mem_req && !bus.mem_ack;
    push = ack && (state == FETCH) && !bus.redirect;
    pop  = (count != '0) && bus.out_ready && !bus.redirect;

    if (bus.redirect) count_next = '0;
    else              count_next = count + CNT_W'(push) - CNT_W'(pop);

    if (bus.redirect) fetch_pc_next = bus.redirect_pc;
    else if (push)    fetch_pc_next = fetch_pc + 32'd4;
    else              fetch_pc_next = fetch_pc;

    // A redirect with the request still waiting must swallow its late response.
    state_mid = state;
    if (bus.redirect) begin
      state_mid = hold ? DISCARD : FETCH;
    end else if (state == DISCARD && ack) begin
      state_mid = FETCH;
    end

    state_next    = state_mid;
    mem_req_next  = 1'b0;
    mem_addr_next = mem_addr;
    if (hold) begin
      mem_req_next = 1'b1;
    end else if (state_mid == FETCH) begin
      mem_addr_next = fetch_pc_next;
      if (addr_bad(fetch_pc_next)) state_next = FAULT;
      else                         mem_req_next = (count_next < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fault    <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      wr_ptr   <= bus.redirect ? '0 : wr_ptr + PTR_W'(push);
      rd_ptr   <= bus.redirect ? '0 : rd_ptr + PTR_W'(pop);
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
      fault    <= (state_next == FAULT);
    end
  end

  // Buffer storage carries data only; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_ins[wr_ptr] <= bus.mem_rdata;
      buf_pc[wr_ptr]  <= mem_addr;
    end
  end

  always_comb begin
    bus.mem_req     = mem_req;
    bus.mem_addr    = mem_addr;
    bus.fetch_fault = fault;
    bus.out_valid   = (count != '0);
    bus.out_ins     = (count != '0) ? buf_ins[rd_ptr] : '0;
    bus.out_pc      = (count != '0) ? buf_pc[rd_ptr]  : '0;
  end
endmodule
